// File: rtl/fir_pkg.sv
// Shared types and helpers for the sequential FIR tap MAC.
// Holds the FSM state enum, fractional-bit default and range limits.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } fir_state_e;

  localparam int FIR_FRAC = 10;

  // Largest value representable in a w-bit signed word.
  function automatic logic signed [63:0] sat_hi(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Smallest value representable in a w-bit signed word.
  function automatic logic signed [63:0] sat_lo(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/fir_tap_mac_delay_line.sv
// TAPS x N sample shift register with shift enable and indexed read.
// Ports: clk_i, rst_ni, shift_i, din_i, idx_i (tap select), dout_o.
module fir_tap_mac_delay_line #(
  parameter int N    = 23,
  parameter int TAPS = 8,
  parameter int AW   = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          shift_i,
  input  logic [N-1:0]  din_i,
  input  logic [AW-1:0] idx_i,
  output logic [N-1:0]  dout_o
);

  logic [N-1:0] d_q [TAPS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < TAPS; i++) begin
        d_q[i] <= '0;
      end
    end else if (shift_i) begin
      d_q[0] <= din_i;
      for (int i = 1; i < TAPS; i++) begin
        d_q[i] <= d_q[i-1];
      end
    end
  end

  assign dout_o = d_q[idx_i];

endmodule

// File: rtl/fir_tap_mac.sv
// Sequential FIR stage: one tap multiply-accumulate per clock.
// Ports: clk, rst (async low), sample_in/sample_valid request,
//   coef_addr/coef_in ROM port, result/result_valid, busy, overrun.
// Build option: FIR_SAT_EN clamps results, otherwise they wrap.
module fir_tap_mac
  import fir_pkg::*;
#(
  parameter int N    = 23,
  parameter int FRAC = FIR_FRAC,
  parameter int TAPS = 8,
  localparam int AW  = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  sample_in,
  input  logic          sample_valid,
  output logic [AW-1:0] coef_addr,
  input  logic [N-1:0]  coef_in,
  output logic [N-1:0]  result,
  output logic          result_valid,
  output logic          busy,
  output logic          overrun
);

  localparam int PW   = 2 * N;
  localparam int ACCW = PW + AW;

  fir_state_e             state_q, state_d;
  logic [AW-1:0]          idx_q, idx_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic [N-1:0]           result_q, result_d;
  logic                   rv_q, rv_d;
  logic                   shift;
  logic                   last;
  logic [N-1:0]           tap;
  logic signed [PW-1:0]   prod;
  logic [N-1:0]           lim;

  fir_tap_mac_delay_line #(
    .N    (N),
    .TAPS (TAPS),
    .AW   (AW)
  ) u_dline (
    .clk_i   (clk),
    .rst_ni  (rst),
    .shift_i (shift),
    .din_i   (sample_in),
    .idx_i   (idx_q),
    .dout_o  (tap)
  );

  assign last = (idx_q == AW'(TAPS - 1));
  assign prod = $signed(tap) * $signed(coef_in);

`ifdef FIR_SAT_EN
  localparam logic signed [ACCW-1:0] HI = ACCW'(sat_hi(N));
  localparam logic signed [ACCW-1:0] LO = ACCW'(sat_lo(N));

  logic signed [ACCW-1:0] r;

  // Arithmetic shift floors toward -inf before clamping.
  assign r = acc_q >>> FRAC;

  always_comb begin
    lim = r[N-1:0];
    if (r > HI) begin
      lim = HI[N-1:0];
    end else if (r < LO) begin
      lim = LO[N-1:0];
    end
  end
`else
  assign lim = acc_q[FRAC +: N];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      rv_q     <= rv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (sample_valid) state_d = MAC;
      MAC:  if (last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d    = idx_q;
    acc_d    = acc_q;
    result_d = result_q;
    rv_d     = 1'b0;
    shift    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sample_valid) begin
          shift = 1'b1;
          idx_d = '0;
          acc_d = '0;
        end
      end
      MAC: begin
        acc_d = acc_q + $signed({{AW{prod[PW-1]}}, prod});
        if (!last) idx_d = idx_q + 1'b1;
      end
      DONE: begin
        result_d = lim;
        rv_d     = 1'b1;
        idx_d    = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    overrun   = sample_valid && (state_q != IDLE);
    coef_addr = (state_q == MAC) ? idx_q : '0;
  end

  assign result       = result_q;
  assign result_valid = rv_q;

endmodule

// File: tb/tb_fir_tap_mac.sv
// Directed bench for fir_tap_mac with TAPS=4, N=23, FRAC=10.
// Expected values are hand-computed; FIR_SAT_EN selects clamp vs wrap.
module tb_fir_tap_mac;

  localparam int N    = 23;
  localparam int FRAC = 10;
  localparam int TAPS = 4;
  localparam int AW   = 2;

`ifdef FIR_SAT_EN
  localparam int P1 = 4194303;
  localparam int P4 = 4194303;
  localparam int M1 = -4194304;
  localparam int M4 = -4194304;
`else
  localparam int P1 = 4194303;
  localparam int P4 = -4;
  localparam int M1 = -4194304;
  localparam int M4 = 0;
`endif

  logic          clk;
  logic          rst;
  logic [N-1:0]  sample_in;
  logic          sample_valid;
  logic [AW-1:0] coef_addr;
  logic [N-1:0]  coef_in;
  logic [N-1:0]  result;
  logic          result_valid;
  logic          busy;
  logic          overrun;

  logic signed [N-1:0] rom [TAPS];

  int checks;
  int failures;
  int cnt;

  fir_tap_mac #(
    .N    (N),
    .FRAC (FRAC),
    .TAPS (TAPS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .coef_addr    (coef_addr),
    .coef_in      (coef_in),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  assign coef_in = rom[coef_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic send(input int s);
    sample_in    = s[N-1:0];
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  // Ticks until result_valid, bounded; checks latency and value.
  task automatic wait_result(input string tag, input int exp,
                             input int lat);
    int n;
    n = 0;
    while (!result_valid && n <= 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk(tag, $signed(result), exp);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic set_rom(input int c0, input int c1,
                         input int c2, input int c3);
    rom[0] = c0[N-1:0];
    rom[1] = c1[N-1:0];
    rom[2] = c2[N-1:0];
    rom[3] = c3[N-1:0];
  endtask

  task automatic count_rv(input int cycles);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (result_valid) cnt++;
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    set_rom(1024, 512, 256, 128);
    tick();
    tick();
    chk("rst_result", $signed(result), 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_addr", coef_addr, 0);
    rst = 1'b1;
    tick();

    // Impulse response
    send(1024);
    chk("imp_busy", busy, 1);
    chk("imp_addr0", coef_addr, 0);
    tick();
    chk("imp_addr1", coef_addr, 1);
    wait_result("imp0", 1024, 4);
    send(0);
    wait_result("imp1", 512, 5);
    send(0);
    wait_result("imp2", 256, 5);
    send(0);
    wait_result("imp3", 128, 5);
    tick();
    chk("hold_rv", result_valid, 0);
    chk("hold_result", $signed(result), 128);
    chk("idle_busy", busy, 0);

    // Positive range limit
    do_reset();
    set_rom(1024, 1024, 1024, 1024);
    send(4194303);
    wait_result("pos1", P1, 5);
    send(4194303);
    wait_result("pos2", (P4 == -4) ? -2 : 4194303, 5);
    send(4194303);
    wait_result("pos3", (P4 == -4) ? 4194301 : 4194303, 5);
    send(4194303);
    wait_result("pos4", P4, 5);

    // Negative range limit
    do_reset();
    send(-4194304);
    wait_result("neg1", M1, 5);
    send(-4194304);
    wait_result("neg2", (M4 == 0) ? 0 : -4194304, 5);
    send(-4194304);
    wait_result("neg3", -4194304, 5);
    send(-4194304);
    wait_result("neg4", M4, 5);

    // Floor toward -inf
    do_reset();
    set_rom(512, 512, 512, 512);
    send(-1);
    wait_result("trunc", -1, 5);

    // Overrun: second request dropped
    do_reset();
    set_rom(1024, 512, 256, 128);
    send(1024);
    tick();
    sample_in    = 23'd2048;
    sample_valid = 1'b1;
    #1;
    chk("ovr_pulse", overrun, 1);
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    #1;
    chk("ovr_clear", overrun, 0);
    wait_result("ovr_res", 1024, 3);
    count_rv(8);
    chk("ovr_single_rv", cnt, 0);
    send(0);
    wait_result("ovr_hist", 512, 5);

    // Reset in the middle of MAC
    send(1024);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_result", $signed(result), 0);
    chk("mid_rv", result_valid, 0);
    chk("mid_addr", coef_addr, 0);
    chk("mid_overrun", overrun, 0);
    tick();
    rst = 1'b1;
    count_rv(8);
    chk("mid_no_rv", cnt, 0);
    send(1024);
    wait_result("re_imp0", 1024, 5);
    send(0);
    wait_result("re_imp1", 512, 5);
    send(0);
    wait_result("re_imp2", 256, 5);
    send(0);
    wait_result("re_imp3", 128, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
